// File: rtl/alu_pkg.sv
// Shared types for the serial add/subtract datapath: operation modes and
// controller states.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    RSUB = 2'b10,
    CMP  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_serial_ripple_slice.sv
// DIGIT-bit ripple full-adder chain; also exposes the carry into its MSB so
// the caller can derive signed overflow on the top slice.
module ripple_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement add/subtract/compare unit. Operands are
// consumed DIGIT bits per clock, LSB first, through one shared ripple slice.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// BUSY  | one slice per edge, N edges total
// DONE  | result and flags held until out_ready
module addsub_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e            state;
  mode_e             mode_r;
  mode_e             mode_in;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  sum_r;
  logic              carry;
  logic [CNT_W-1:0]  cnt;

  logic [WIDTH-1:0]  ld_a;
  logic [WIDTH-1:0]  ld_b;
  logic              ld_cin;
  logic              accept;

  logic [DIGIT-1:0]  s_sum;
  logic              s_cout;
  logic              s_cmsb;
  logic [WIDTH-1:0]  a_next;
  logic [WIDTH-1:0]  b_next;
  logic [WIDTH-1:0]  sum_next;

  assign mode_in  = mode_e'(mode);
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // RSUB swaps the operands so the adder always computes first + ~second + 1.
  always_comb begin
    ld_a   = op_a;
    ld_b   = op_b;
    ld_cin = 1'b0;
    case (mode_in)
      ADD: begin
        ld_a   = op_a;
        ld_b   = op_b;
        ld_cin = 1'b0;
      end
      RSUB: begin
        ld_a   = op_b;
        ld_b   = ~op_a;
        ld_cin = 1'b1;
      end
      default: begin
        ld_a   = op_a;
        ld_b   = ~op_b;
        ld_cin = 1'b1;
      end
    endcase
  end

  ripple_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .sum   (s_sum),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  // Operands shift down one digit per edge; finished sum digits enter at the top.
  if (DIGIT == WIDTH) begin : g_single
    assign a_next   = '0;
    assign b_next   = '0;
    assign sum_next = s_sum;
  end else begin : g_multi
    assign a_next   = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
    assign b_next   = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
    assign sum_next = {s_sum, sum_r[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_r    <= ADD;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_r     <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (accept) begin
      state     <= BUSY;
      mode_r    <= mode_in;
      a_sh      <= ld_a;
      b_sh      <= ld_b;
      carry     <= ld_cin;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          a_sh  <= a_next;
          b_sh  <= b_next;
          sum_r <= sum_next;
          carry <= s_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= (mode_r == CMP) ? '0 : {s_cout, sum_next};
            flag_c    <= s_cout;
            flag_z    <= (sum_next == '0);
            flag_n    <= sum_next[WIDTH-1];
            flag_v    <= s_cmsb ^ s_cout;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench: three instances (DIGIT = 1, 2, 8) share stimulus and are
// checked against hand-computed results, flags and latencies.
module tb_addsub_serial;

  localparam int W  = 8;
  localparam int NI = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             out_ready;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [1:0]       mode;

  logic [NI-1:0]    in_ready;
  logic [NI-1:0]    out_valid;
  logic [NI-1:0]    fc, fz, fn, fv;
  logic [W:0]       result [NI];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DG = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    addsub_serial #(
      .WIDTH (W),
      .DIGIT (DG)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .op_a      (op_a),
      .op_b      (op_b),
      .mode      (mode),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .result    (result[g]),
      .flag_c    (fc[g]),
      .flag_z    (fz[g]),
      .flag_n    (fn[g]),
      .flag_v    (fv[g])
    );
  end

  function automatic int dig(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 8;
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (DIGIT=%0d): got 0x%0h, expected 0x%0h", tag, dig(idx), got, exp);
    end
  endtask

  task automatic check_hold(input string tag, input logic [8:0] er, input logic [3:0] ef);
    for (int i = 0; i < NI; i++) begin
      check({tag, "_valid"}, i, 32'(out_valid[i]), 32'd1);
      check({tag, "_result"}, i, 32'(result[i]), 32'(er));
      check({tag, "_flags"}, i, 32'({fc[i], fz[i], fn[i], fv[i]}), 32'(ef));
    end
  endtask

  // Issues one operation (doubling as the handshake for any held result),
  // scrambles the inputs after acceptance, then measures latency and checks.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [7:0] a,
                        input logic [7:0] b, input logic [8:0] er, input logic [3:0] ef);
    int lat [NI];
    @(negedge clk);
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    mode      = m;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = ~a;
    op_b      = ~b;
    mode      = m ^ 2'b01;
    for (int i = 0; i < NI; i++) begin
      lat[i] = 0;
      check({tag, "_accept_ov"}, i, 32'(out_valid[i]), 32'd0);
      check({tag, "_busy_rdy"}, i, 32'(in_ready[i]), 32'd0);
    end
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
        if (lat[i] == 0 && out_valid[i]) lat[i] = e;
    end
    for (int i = 0; i < NI; i++)
      check({tag, "_latency"}, i, 32'(lat[i]), 32'(W / dig(i)));
    check_hold(tag, er, ef);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check({tag, "_ov"}, i, 32'(out_valid[i]), 32'd0);
      check({tag, "_rdy"}, i, 32'(in_ready[i]), 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    mode      = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_rdy", i, 32'(in_ready[i]), 32'd1);
      check("rst_ov", i, 32'(out_valid[i]), 32'd0);
      check("rst_result", i, 32'(result[i]), 32'd0);
      check("rst_flags", i, 32'({fc[i], fz[i], fn[i], fv[i]}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // flags packed as {C, Z, N, V}
    run_op("add_7f_01", 2'b00, 8'h7F, 8'h01, 9'h080, 4'b0011);
    run_op("sub_05_05", 2'b01, 8'h05, 8'h05, 9'h100, 4'b1100);
    run_op("sub_03_05", 2'b01, 8'h03, 8'h05, 9'h0FE, 4'b0010);
    run_op("rsub_03_05", 2'b10, 8'h03, 8'h05, 9'h102, 4'b1000);
    run_op("cmp_80_01", 2'b11, 8'h80, 8'h01, 9'h000, 4'b1001);

    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_hold("bp_hold", 9'h000, 4'b1001);
      for (int i = 0; i < NI; i++)
        check("bp_rdy", i, 32'(in_ready[i]), 32'd0);
    end

    run_op("b2b_add_01_01", 2'b00, 8'h01, 8'h01, 9'h002, 4'b0000);
    run_op("add_80_80", 2'b00, 8'h80, 8'h80, 9'h100, 4'b1101);
    drain("drain");

    // abort during the second BUSY cycle of the DIGIT=2 instance
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = 8'h12;
    op_b     = 8'h34;
    mode     = 2'b00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("abort_ov", i, 32'(out_valid[i]), 32'd0);
      check("abort_rdy", i, 32'(in_ready[i]), 32'd1);
      check("abort_result", i, 32'(result[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      check("abort_no_ov", i, 32'(out_valid[i]), 32'd0);

    run_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 9'h100, 4'b1100);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle two's-complement add/subtract unit with ALU status flags.
- Processes DIGIT bits per clock, LSB first, using a ripple full-adder slice, so logic area stays constant as WIDTH grows.
- Generalises the fixed 4-bit combinational subtractor with selectable add, subtract, reverse-subtract and compare modes, a carry/borrow output and valid/ready handshakes.
- Sits between the operand register file and the ALU result mux.

Parameters:
- WIDTH, 8, operand width in bits. Must be at least 2 and an integer multiple of DIGIT.
- DIGIT, 2, bits processed per cycle, from 1 to WIDTH. N = WIDTH/DIGIT is the number of compute cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  unit can accept an operation.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- mode  in  2  operation select: 00 ADD (A+B), 01 SUB (A-B), 10 RSUB (B-A), 11 CMP (A-B, flags only).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH+1  bit WIDTH is the raw final carry-out; bits WIDTH-1 to 0 are the sum.
- flag_c  out  1  raw carry-out. For SUB, RSUB and CMP, 1 means no borrow.
- flag_z  out  1  sum bits all zero.
- flag_n  out  1  sum bit WIDTH-1.
- flag_v  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high.
  - While rst is high: state is IDLE; out_valid, result and all flags are 0; in_ready is 1.
  - Reset mid-operation aborts the operation. No out_valid is produced, and the next accepted operation is unaffected.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: in_ready=1. When in_valid=1, the accepting edge latches op_a, op_b and mode, clears the slice counter and enters BUSY.
  - Operand setup at acceptance:
    - Second operand is ~op_b for SUB/CMP and ~op_a for RSUB.
    - First operand is op_b for RSUB.
    - carry_in is 1 for SUB/RSUB/CMP and 0 for ADD.
  - BUSY: in_ready=0.
    - Each edge computes slice k (bits k*DIGIT to k*DIGIT+DIGIT-1) through the full-adder slice, stores the sum bits, registers the carry and increments k.
    - Carry into the MSB is captured when the MSB is processed, for flag_v.
    - After N edges in BUSY, enter DONE.
    - Latency from the accepting edge to out_valid high is exactly N edges.
  - DONE: out_valid=1.
    - result and flags stay stable until out_valid and out_ready are both 1.
    - On that handshake edge: if in_valid=1, accept a new operation and go to BUSY; otherwise go to IDLE.
    - in_ready = IDLE OR (DONE AND out_ready), so back-to-back throughput is one operation per N+1 cycles.
- CMP: result is forced to 0. Flags are those of A-B.
- Wrap-around: the sum is modulo 2^WIDTH. The carry-out is never lost; it is always in result[WIDTH].
- Operand changes: op_a, op_b and mode are ignored while in_ready=0. Changes after acceptance have no effect.
- DIGIT=WIDTH: N=1, so there is a single BUSY cycle.

Decomposition:
- Shared package alu_pkg holds:
  - the mode enum: ADD=2'b00, SUB=2'b01, RSUB=2'b10, CMP=2'b11;
  - the FSM state enum: IDLE, BUSY, DONE.
- Sub-module ripple_slice: combinational DIGIT-bit full-adder chain.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (carry into the slice MSB).
  - Instantiated once and reused every cycle.

Test Plan:
- WIDTH=8, DIGIT=2, ADD 0x7F+0x01: out_valid high 4 edges after acceptance; result=0x080, C=0, Z=0, N=1, V=1.
- SUB 0x05-0x05: result=0x100, C=1, Z=1, N=0, V=0.
- SUB 0x03-0x05: result=0x0FE, C=0 (borrow), N=1, V=0. Then RSUB with the same operands: result=0x102, C=1, N=0.
- CMP 0x80-0x01: result=0x000, C=1, Z=0, N=0, V=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE: result/flags stable, in_ready=0.
  - Raise out_ready with in_valid=1 (ADD 0x01+0x01): handshake and new accept on the same edge; result 0x002 after 4 more edges.
- Reset and parameter sweep:
  - Assert rst during the 2nd BUSY cycle: out_valid=0 and in_ready=1 immediately; the next ADD 0xFF+0x01 gives 0x100, Z=1, C=1.
  - Repeat all cases with DIGIT=1 (latency 8) and DIGIT=8 (latency 1).
